fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word reads to instruction memory.
- Buffers returned 16-bit instructions in a small queue and presents them to decode with a valid/ready handshake.
- Accepts redirects from the execute stage (branch/JAL/JALR) and squashes stale fetches.

Parameters:
- PC_W, 16, width of PC and instruction-memory address (word-addressed, one 16-bit instruction per word)
- RESET_PC, 16'h0000, PC value loaded on reset
- QDEPTH, 2, instruction queue entries (power of two, >=2)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- imem_req  output  1  read request; held until imem_gnt
- imem_addr  output  PC_W  read address; stable while imem_req high
- imem_gnt  input  1  memory accepted request this cycle
- imem_rvalid  input  1  read data valid, at least 1 cycle after grant, in order
- imem_rdata  input  16  instruction word
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  PC_W  new fetch address
- out_valid  output  1  out_inst/out_pc valid to decoder
- out_ready  input  1  decoder accepts this cycle
- out_inst  output  16  instruction to decoder instIn
- out_pc  output  PC_W  address of out_inst

Behaviour:
- Reset (rst_n low at clk edge):
  - pc=RESET_PC, queue empty, FSM=IDLE.
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=16'h0000, out_pc=0.
- At most one memory request outstanding (granted, not yet returned).
- FSM states:
  - IDLE: imem_req=1 when (queue count + 0) < QDEPTH and no redirect this cycle. On imem_gnt, go to WAIT and latch req_pc=pc; pc <= pc+1 (mod 2^PC_W; wrap from all-ones to 0 is legal).
  - WAIT: on imem_rvalid, push {imem_rdata, req_pc} into queue and go to IDLE. The next request may be issued in the same cycle as rvalid if space remains after the push/pop.
  - DISCARD: entered when a redirect arrives in WAIT. The next imem_rvalid is dropped (not pushed). Then go to IDLE. No new request is issued while in DISCARD.
- Queue:
  - FIFO with out_valid = !empty; out_inst/out_pc come from the head, combinationally from registered storage.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are allowed when full: count stays constant.
  - Never push when full. The request gate guarantees this: a request is issued only if count < QDEPTH, counting the outstanding slot.
- Redirect (highest priority):
  - In the cycle redirect_valid=1: the queue is cleared (out_valid=0 next cycle), pc <= redirect_pc, and imem_req is forced 0 that cycle.
  - A pop by the decoder in the same cycle is still considered taken by the decoder; the redirect source owns squashing it.
  - State transitions: IDLE stays IDLE; WAIT goes to DISCARD; DISCARD stays DISCARD.
  - If imem_rvalid arrives in the same cycle as the redirect while in WAIT, that data is dropped and the FSM goes to IDLE, not DISCARD.
  - A request already presented but not yet granted is withdrawn. A withdrawn request is legal for the memory because nothing was granted.
- imem_req/imem_addr are registered-stable: once imem_req is high, addr does not change until gnt or redirect.
- Minimum latency: redirect at cycle N → imem_req with redirect_pc at N+1 (if not DISCARD) → with 1-cycle memory, out_valid at N+3.
- Steady state with 1-cycle memory: one instruction every 2 cycles (single outstanding).

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined: adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0.
  - perf_fetched increments on each queue push.
  - perf_stall increments on each cycle with out_valid=0 and no redirect.
  - Both saturate at 32'hFFFFFFFF and do not wrap.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then 1-cycle memory returning imem_rdata=addr^16'hA5A5, out_ready=1 → out_pc sequence 0,1,2,3 with matching out_inst; first out_valid 3 cycles after reset release.
- out_ready=0 for 10 cycles → exactly QDEPTH=2 instructions buffered, imem_req low once full, no overflow; release → PCs 0,1 delivered then fetch resumes at 2.
- Redirect to 16'h0040 while in WAIT with 3-cycle memory latency → stale response dropped; next out_pc=16'h0040, never the stale PC.
- Redirect in the same cycle as imem_rvalid → data dropped, FSM in IDLE, request for redirect_pc issued the next cycle.
- RESET_PC=16'hFFFF → out_pc sequence FFFF,0000,0001 (wrap).
- FETCH_PERF_EN defined: 5 instructions fetched with an initial 3-cycle stall → perf_fetched=5, perf_stall counts empty cycles exactly; reset mid-run clears both to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, QDEPTH-entry queue to decode.
// Latency: redirect at N -> request at N+1 -> out_valid at N+3 with 1-cycle memory. Optional FETCH_PERF_EN.
// Backpressure: out_ready low fills the queue, and the request gate then holds imem_req low.

module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_vld) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
endmodule

module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [15:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_inst,
`ifdef FETCH_PERF_EN
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`else
    output logic [PC_W-1:0] out_pc
`endif
);
    localparam int              QW    = PC_W + 16;
    localparam int              CW    = $clog2(QDEPTH+1);
    localparam logic [CW-1:0]   QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DISCARD} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q;
    logic            run_q;
    logic            push;
    logic            pop;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    logic [QW-1:0]   q_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            run_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= 1'b1;
            if (imem_req && imem_gnt) req_pc_q <= pc_q;
        end
    end

    // No request while a response is outstanding, so IDLE only needs the queue level.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        imem_req = 1'b0;
        push     = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            case (state_q)
                ST_WAIT:    state_d = imem_rvalid ? ST_IDLE : ST_DISCARD;
                ST_DISCARD: state_d = imem_rvalid ? ST_IDLE : ST_DISCARD;
                default:    state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    imem_req = run_q && (q_count < QFULL);
                    if (imem_req && imem_gnt) begin
                        state_d = ST_WAIT;
                        pc_d    = pc_q + PC_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rvalid) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pop       = out_valid && out_ready;

    fetch_fifo #(.W(QW), .DEPTH(QDEPTH)) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (redirect_valid),
        .push_vld (push),
        .push_dat ({imem_rdata, req_pc_q}),
        .pop      (pop),
        .head_dat (q_head),
        .empty    (q_empty),
        .count    (q_count)
    );

    assign out_valid = !q_empty;
    assign out_inst  = out_valid ? q_head[PC_W +: 16] : 16'h0000;
    assign out_pc    = out_valid ? q_head[PC_W-1:0]   : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (!out_valid && !redirect_valid && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance plus a RESET_PC=16'hFFFF instance for PC wrap.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        redir = 1'b0;
    logic [15:0] redir_pc = 16'h0000;

    logic        req0, gnt0, ov0;
    logic        rv0 = 1'b0;
    logic [15:0] rd0 = 16'h0000;
    logic        ordy0 = 1'b0;
    logic        gnt_en0 = 1'b1;
    logic [15:0] addr0, oinst0, opc0;
    int          lat0 = 1;

    logic        req1, gnt1, ov1;
    logic        rv1 = 1'b0;
    logic [15:0] rd1 = 16'h0000;
    logic [15:0] addr1, oinst1, opc1;

`ifdef FETCH_PERF_EN
    logic [31:0] pf0, ps0, pf1, ps1;
`endif

    int tests = 0;
    int fails = 0;

    assign gnt0 = req0 & gnt_en0;
    assign gnt1 = req1;

    fetch_unit dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req0), .imem_addr(addr0), .imem_gnt(gnt0),
        .imem_rvalid(rv0), .imem_rdata(rd0),
        .redirect_valid(redir), .redirect_pc(redir_pc),
        .out_valid(ov0), .out_ready(ordy0), .out_inst(oinst0),
`ifdef FETCH_PERF_EN
        .out_pc(opc0), .perf_fetched(pf0), .perf_stall(ps0)
`else
        .out_pc(opc0)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1),
        .imem_rvalid(rv1), .imem_rdata(rd1),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .out_valid(ov1), .out_ready(1'b1), .out_inst(oinst1),
`ifdef FETCH_PERF_EN
        .out_pc(opc1), .perf_fetched(pf1), .perf_stall(ps1)
`else
        .out_pc(opc1)
`endif
    );

    // Memory models: grant captured at the edge, response driven lat cycles later.
    logic        g0 = 1'b0, g1 = 1'b0;
    logic [15:0] ga0, ga1, pa0, pa1;
    int          cnt0 = 0, cnt1 = 0;

    always @(posedge clk) begin
        g0  <= req0 && gnt0;
        ga0 <= addr0;
        g1  <= req1 && gnt1;
        ga1 <= addr1;
    end

    always @(negedge clk) begin
        rv0 = 1'b0;
        rv1 = 1'b0;
        if (!rst_n) begin
            cnt0 = 0;
            cnt1 = 0;
        end else begin
            if (g0) begin cnt0 = lat0; pa0 = ga0; end
            if (cnt0 > 0) begin
                cnt0--;
                if (cnt0 == 0) begin rv0 = 1'b1; rd0 = pa0 ^ 16'hA5A5; end
            end
            if (g1) begin cnt1 = 1; pa1 = ga1; end
            if (cnt1 > 0) begin
                cnt1--;
                if (cnt1 == 0) begin rv1 = 1'b1; rd1 = pa1 ^ 16'hA5A5; end
            end
        end
    end

    logic [15:0] log1_pc[$];
    logic [15:0] log1_inst[$];
    always @(posedge clk) begin
        if (rst_n && ov1) begin
            log1_pc.push_back(opc1);
            log1_inst.push_back(oinst1);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle whose closing edge sees rst_n high.
    task automatic do_reset();
        step();
        rst_n = 1'b0; redir = 1'b0; ordy0 = 1'b0; gnt_en0 = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b0;
        repeat (2) step();
        tests++; if (req0 !== 1'b0)       begin fails++; $display("FAIL reset_req: got %b want 0", req0); end
        tests++; if (addr0 !== 16'h0000)  begin fails++; $display("FAIL reset_addr: got %h want 0000", addr0); end
        tests++; if (ov0 !== 1'b0)        begin fails++; $display("FAIL reset_valid: got %b want 0", ov0); end
        tests++; if (oinst0 !== 16'h0000) begin fails++; $display("FAIL reset_inst: got %h want 0000", oinst0); end
        tests++; if (opc0 !== 16'h0000)   begin fails++; $display("FAIL reset_pc: got %h want 0000", opc0); end
        tests++; if (addr1 !== 16'hFFFF)  begin fails++; $display("FAIL reset_addr_ffff: got %h want ffff", addr1); end
`ifdef FETCH_PERF_EN
        tests++; if (pf0 !== 32'd0 || ps0 !== 32'd0) begin
            fails++; $display("FAIL reset_perf: got %0d/%0d want 0/0", pf0, ps0);
        end
`endif
        rst_n = 1'b1;
        #1;
        tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL release_req: got %b want 0", req0); end
    endtask

    task automatic test_basic();
        int first;
        int n;
        int last;
        logic [15:0] exp_pc;
        do_reset();
        lat0 = 1; ordy0 = 1'b1;
        first = -1; n = 0; last = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (ov0) begin
                if (first < 0) first = c;
                exp_pc = 16'(n);
                tests++;
                if (opc0 !== exp_pc || oinst0 !== (exp_pc ^ 16'hA5A5)) begin
                    fails++;
                    $display("FAIL basic_seq%0d: got pc=%h inst=%h want pc=%h inst=%h",
                             n, opc0, oinst0, exp_pc, exp_pc ^ 16'hA5A5);
                end
                n++;
                last = c;
            end
        end
        tests++; if (first != 3) begin fails++; $display("FAIL basic_first_valid: cycle %0d want 3", first); end
        tests++; if (n != 4 || last != 9) begin
            fails++; $display("FAIL basic_rate: got %0d insts last at %0d want 4 at 9", n, last);
        end
    endtask

    task automatic test_backpressure();
        int grants;
        int req_late;
        int n;
        logic [15:0] exp_pc;
        do_reset();
        lat0 = 1; ordy0 = 1'b0;
        grants = 0; req_late = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (req0 && gnt0) grants++;
            if (c >= 5 && req0) req_late++;
        end
        tests++; if (grants != 2)   begin fails++; $display("FAIL bp_grants: got %0d want 2", grants); end
        tests++; if (req_late != 0) begin fails++; $display("FAIL bp_req_low: got %0d high cycles want 0", req_late); end
        tests++; if (ov0 !== 1'b1 || opc0 !== 16'h0000 || oinst0 !== 16'hA5A5) begin
            fails++; $display("FAIL bp_head: got v=%b pc=%h inst=%h want 1/0000/a5a5", ov0, opc0, oinst0);
        end
        ordy0 = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (ov0 && n < 3) begin
                exp_pc = 16'(n);
                tests++;
                if (opc0 !== exp_pc || oinst0 !== (exp_pc ^ 16'hA5A5)) begin
                    fails++; $display("FAIL bp_drain%0d: got pc=%h inst=%h want pc=%h", n, opc0, oinst0, exp_pc);
                end
                n++;
            end
            step();
        end
        tests++; if (n != 3) begin fails++; $display("FAIL bp_drain_count: got %0d want 3", n); end
    endtask

    task automatic test_redirect_wait();
        int seen;
        do_reset();
        lat0 = 3; ordy0 = 1'b1;
        step();
        tests++; if (req0 !== 1'b1 || addr0 !== 16'h0000) begin
            fails++; $display("FAIL rw_first_req: got %b/%h want 1/0000", req0, addr0);
        end
        step();
        redir = 1'b1; redir_pc = 16'h0040;
        #1;
        tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL rw_req_forced: got %b want 0", req0); end
        step();
        redir = 1'b0;
        #1;
        tests++; if (req0 !== 1'b0 || ov0 !== 1'b0) begin
            fails++; $display("FAIL rw_discard_c3: got req=%b v=%b want 0/0", req0, ov0);
        end
        step();
        tests++; if (req0 !== 1'b0 || ov0 !== 1'b0) begin
            fails++; $display("FAIL rw_discard_c4: got req=%b v=%b want 0/0", req0, ov0);
        end
        step();
        tests++; if (req0 !== 1'b1 || addr0 !== 16'h0040) begin
            fails++; $display("FAIL rw_new_req: got %b/%h want 1/0040", req0, addr0);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (ov0 && seen == 0) begin
                seen = 1;
                tests++;
                if (opc0 !== 16'h0040 || oinst0 !== (16'h0040 ^ 16'hA5A5)) begin
                    fails++; $display("FAIL rw_first_out: got pc=%h inst=%h want 0040/%h", opc0, oinst0, 16'h0040 ^ 16'hA5A5);
                end
            end
        end
        tests++; if (seen == 0) begin fails++; $display("FAIL rw_timeout: got no out_valid want one"); end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        lat0 = 1; ordy0 = 1'b1;
        step();
        step();
        redir = 1'b1; redir_pc = 16'h0100;
        step();
        redir = 1'b0;
        #1;
        tests++; if (req0 !== 1'b1 || addr0 !== 16'h0100 || ov0 !== 1'b0) begin
            fails++; $display("FAIL rr_next_req: got req=%b addr=%h v=%b want 1/0100/0", req0, addr0, ov0);
        end
        step();
        tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL rr_dropped: got v=%b pc=%h want 0", ov0, opc0); end
        step();
        tests++; if (ov0 !== 1'b1 || opc0 !== 16'h0100 || oinst0 !== (16'h0100 ^ 16'hA5A5)) begin
            fails++; $display("FAIL rr_out: got v=%b pc=%h inst=%h want 1/0100/%h", ov0, opc0, oinst0, 16'h0100 ^ 16'hA5A5);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000; exp_pc[2] = 16'h0001;
        do_reset();
        log1_pc.delete();
        log1_inst.delete();
        repeat (10) step();
        tests++;
        if (log1_pc.size() < 3) begin
            fails++; $display("FAIL wrap_count: got %0d insts want >=3", log1_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (log1_pc[i] !== exp_pc[i] || log1_inst[i] !== (exp_pc[i] ^ 16'hA5A5)) begin
                    fails++; $display("FAIL wrap_seq%0d: got pc=%h inst=%h want pc=%h", i, log1_pc[i], log1_inst[i], exp_pc[i]);
                end
                if (i < 2) tests++;
            end
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        lat0 = 1; ordy0 = 1'b1; gnt_en0 = 1'b0;
        repeat (3) step();
        step();
        gnt_en0 = 1'b1;
        repeat (11) step();
        tests++; if (pf0 !== 32'd5)  begin fails++; $display("FAIL perf_fetched: got %0d want 5", pf0); end
        tests++; if (ps0 !== 32'd10) begin fails++; $display("FAIL perf_stall: got %0d want 10", ps0); end
        rst_n = 1'b0;
        step();
        tests++; if (pf0 !== 32'd0 || ps0 !== 32'd0) begin
            fails++; $display("FAIL perf_clear: got %0d/%0d want 0/0", pf0, ps0);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
